// File: rtl/fp_scoreboard.sv
// FP register scoreboard: tracks pending FP writes, raises RAW/WAW/structural stalls,
// and schedules a single writeback slot per cycle through a latency-indexed shift register.
module fp_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        IssueD,
  input  logic        ExtStallD,
  input  logic        FpWriteD,
  input  logic [4:0]  RdD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs3D,
  input  logic [2:0]  FpSrcD,
  input  logic [2:0]  LatD,
  input  logic        CancelE,
  output logic        FpStallD,
  output logic        WbValidW,
  output logic [4:0]  WbRdW,
  output logic [31:0] BusyMask
);
  localparam int NSLOT = 7;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic [2:0] lat;
  } rec_t;

  // Position k of the pipe reaches writeback k cycles from now; position 0 is the W slot.
  logic [NSLOT:0]       vld_pipe, vld_nxt;
  logic [NSLOT:0][4:0]  rd_pipe, rd_nxt;
  logic [31:0]          busy_nxt, busy_eff;
  rec_t                 rec, rec_nxt;

  logic [2:0] lat;
  logic       raw_hit, waw_hit, slot_hit;
  logic       issue_go, set_rsv, cancel_hit;

  assign WbValidW = vld_pipe[0];
  assign WbRdW    = rd_pipe[0];

  assign lat = (LatD == 3'd0) ? 3'd1 : LatD;

  // A register being written back this cycle is readable/rewritable without stalling.
  assign busy_eff = BusyMask & ~(WbValidW ? (32'd1 << WbRdW) : 32'd0);

  assign raw_hit  = |(FpSrcD & {busy_eff[Rs3D], busy_eff[Rs2D], busy_eff[Rs1D]});
  assign waw_hit  = FpWriteD & busy_eff[RdD];
  assign slot_hit = FpWriteD & vld_pipe[lat];
  assign FpStallD = IssueD & (raw_hit | waw_hit | slot_hit);

  assign issue_go   = IssueD & ~ExtStallD & ~FpStallD & ~CancelE;
  assign set_rsv    = issue_go & FpWriteD;
  assign cancel_hit = CancelE & rec.vld;

  always_comb begin
    vld_nxt  = {1'b0, vld_pipe[NSLOT:1]};
    rd_nxt   = {5'd0, rd_pipe[NSLOT:1]};
    busy_nxt = BusyMask;
    rec_nxt  = '{vld: set_rsv, rd: RdD, lat: lat};

    if (WbValidW)
      busy_nxt[WbRdW] = 1'b0;

    // The flushed issue sits at pipe position lat-1 now, so lat-2 after this shift.
    // With lat==1 its writeback is already on W and only the busy bit is dropped.
    if (cancel_hit) begin
      busy_nxt[rec.rd] = 1'b0;
      if (rec.lat >= 3'd2) begin
        vld_nxt[rec.lat - 3'd2] = 1'b0;
        rd_nxt[rec.lat - 3'd2]  = 5'd0;
      end
    end

    if (set_rsv) begin
      vld_nxt[lat - 3'd1] = 1'b1;
      rd_nxt[lat - 3'd1]  = RdD;
      busy_nxt[RdD]       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      rd_pipe  <= '0;
      BusyMask <= '0;
      rec      <= '0;
    end else begin
      vld_pipe <= vld_nxt;
      rd_pipe  <= rd_nxt;
      BusyMask <= busy_nxt;
      rec      <= rec_nxt;
    end
  end
endmodule

// File: tb/tb_fp_scoreboard.sv
// Bench for fp_scoreboard: directed scenarios plus random traffic checked against
// a reservation-list model keyed by absolute writeback cycle.
module tb_fp_scoreboard;
  logic        clk = 1'b0;
  logic        reset, IssueD, ExtStallD, FpWriteD, CancelE;
  logic [4:0]  RdD, Rs1D, Rs2D, Rs3D;
  logic [2:0]  FpSrcD, LatD;
  logic        FpStallD, WbValidW;
  logic [4:0]  WbRdW;
  logic [31:0] BusyMask;

  fp_scoreboard dut (
    .clk(clk), .reset(reset), .IssueD(IssueD), .ExtStallD(ExtStallD),
    .FpWriteD(FpWriteD), .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs3D(Rs3D),
    .FpSrcD(FpSrcD), .LatD(LatD), .CancelE(CancelE), .FpStallD(FpStallD),
    .WbValidW(WbValidW), .WbRdW(WbRdW), .BusyMask(BusyMask)
  );

  always #5 clk = ~clk;

  typedef struct { int rd; int wb; } res_t;
  res_t q[$];
  int   now = 0;
  bit   last_v = 0;
  int   last_wb = 0;
  int   errs = 0, checks = 0;
  logic obs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy(input int r);
    foreach (q[i]) if (q[i].rd == r && q[i].wb >= now) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_occupied(input int c);
    foreach (q[i]) if (q[i].wb == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_wb_rd();
    foreach (q[i]) if (q[i].wb == now) return q[i].rd;
    return -1;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then advance.
  task automatic step(input bit iss, input bit ext, input bit fw, input int rd,
                      input int rs1, input int rs2, input int rs3, input int src,
                      input int latd, input bit can, input bit rst);
    int L, wrd;
    bit es, go;
    logic [31:0] eb;
    res_t nq[$];
    IssueD = iss; ExtStallD = ext; FpWriteD = fw; RdD = 5'(rd);
    Rs1D = 5'(rs1); Rs2D = 5'(rs2); Rs3D = 5'(rs3); FpSrcD = 3'(src);
    LatD = 3'(latd); CancelE = can; reset = rst;
    #1;
    L   = (latd == 0) ? 1 : latd;
    wrd = m_wb_rd();
    eb  = '0;
    for (int r = 0; r < 32; r++) eb[r] = m_busy(r);
    es = 1'b0;
    if (iss) begin
      if (src[0] && m_busy(rs1) && wrd != rs1) es = 1'b1;
      if (src[1] && m_busy(rs2) && wrd != rs2) es = 1'b1;
      if (src[2] && m_busy(rs3) && wrd != rs3) es = 1'b1;
      if (fw && m_busy(rd) && wrd != rd) es = 1'b1;
      if (fw && m_occupied(now + L)) es = 1'b1;
    end
    chk("busy_mask", BusyMask, eb);
    chk("wb_valid", {31'd0, WbValidW}, {31'd0, wrd >= 0});
    if (wrd >= 0) chk("wb_rd", {27'd0, WbRdW}, wrd);
    chk("fp_stall", {31'd0, FpStallD}, {31'd0, es});
    obs_stall = FpStallD;
    go = iss && !ext && !es && !can;
    @(posedge clk);
    if (rst) begin
      q.delete();
      last_v = 1'b0;
    end else begin
      if (can && last_v) begin
        foreach (q[i]) if (q[i].wb != last_wb) nq.push_back(q[i]);
        q = nq;
        nq.delete();
      end
      last_v = go && fw;
      if (go && fw) begin
        q.push_back('{rd: rd, wb: now + L});
        last_wb = now + L;
      end
      foreach (q[i]) if (q[i].wb > now) nq.push_back(q[i]);
      q = nq;
    end
    now++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic issue(input int rd, input int latd);
    step(1, 0, 1, rd, 0, 0, 0, 0, latd, 0, 0);
  endtask

  initial begin
    reset = 1'b1; IssueD = 0; ExtStallD = 0; FpWriteD = 0; CancelE = 0;
    RdD = 0; Rs1D = 0; Rs2D = 0; Rs3D = 0; FpSrcD = 0; LatD = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", BusyMask, 32'd0);
    chk("rst_wbv", {31'd0, WbValidW}, 32'd0);
    chk("rst_wbrd", {27'd0, WbRdW}, 32'd0);
    // Any inputs in the first post-reset cycle must leave the stall low.
    step(1, 0, 1, 3, 3, 3, 3, 7, 2, 0, 0);
    chk("rst_stall", {31'd0, obs_stall}, 32'd0);
    idle(8);

    // f3, L=4: busy for 4 cycles, writeback on the 4th, clear after.
    issue(3, 4);
    chk("l4_busy1", {31'd0, BusyMask[3]}, 32'd1);
    idle(3);
    chk("l4_busy4", {31'd0, BusyMask[3]}, 32'd1);
    chk("l4_wbv", {31'd0, WbValidW}, 32'd1);
    chk("l4_wbrd", {27'd0, WbRdW}, 32'd3);
    idle(1);
    chk("l4_clear", {31'd0, BusyMask[3]}, 32'd0);
    idle(8);

    // RAW on f5 stalls two cycles, released by the writeback bypass.
    issue(5, 3);
    step(1, 0, 0, 0, 5, 0, 0, 1, 1, 0, 0);
    chk("raw_t1", {31'd0, obs_stall}, 32'd1);
    step(1, 0, 0, 0, 5, 0, 0, 1, 1, 0, 0);
    chk("raw_t2", {31'd0, obs_stall}, 32'd1);
    step(1, 0, 0, 0, 5, 0, 0, 1, 1, 0, 0);
    chk("raw_t3", {31'd0, obs_stall}, 32'd0);
    idle(8);

    // Structural conflict on the writeback slot, then a non-conflicting latency.
    issue(1, 5);
    step(1, 0, 1, 2, 0, 0, 0, 0, 4, 0, 0);
    chk("struct_stall", {31'd0, obs_stall}, 32'd1);
    idle(8);
    issue(1, 5);
    issue(2, 3);
    idle(2);
    chk("ooo_wb2", {26'd0, WbValidW, WbRdW}, {26'd0, 1'b1, 5'd2});
    idle(1);
    chk("ooo_wb1", {26'd0, WbValidW, WbRdW}, {26'd0, 1'b1, 5'd1});
    idle(8);

    // Cancel of the previous-cycle issue removes its reservation and writeback.
    issue(7, 6);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("cancel_busy", {31'd0, BusyMask[7]}, 32'd0);
    idle(4);
    chk("cancel_nowb", {31'd0, WbValidW}, 32'd0);
    idle(4);

    // Issue blocked by a same-cycle cancel or an external stall.
    step(1, 0, 1, 4, 0, 0, 0, 0, 2, 1, 0);
    chk("iss_cancel", BusyMask, 32'd0);
    step(1, 1, 1, 4, 0, 0, 0, 0, 2, 0, 0);
    chk("iss_ext", BusyMask, 32'd0);
    idle(8);

    // Reset mid-flight discards the f9 reservation.
    issue(9, 7);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("midrst_busy", BusyMask, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("midrst_nowb", {31'd0, WbValidW}, 32'd0);
      idle(1);
    end
    chk("midrst_nowb_end", {31'd0, WbValidW}, 32'd0);

    // Random traffic on a small register range to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 6) == 0, $urandom_range(0, 79) == 0);
    end
    idle(9);
    chk("drain_busy", BusyMask, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
